// File: rtl/vga_timing.sv
// Free-running raster generator: pixel coordinates, sync pulses and blanking, all registered and aligned.
// Define VGA_TIMING_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_cnt is tied to zero.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_tick,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ACT   = (SYNC_POL != 0);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_display_on;

    logic       w_x_last;
    logic       w_y_last;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_hs_win;
    logic       w_vs_win;
    logic       w_disp_nxt;

    assign w_x_last = (r_x == H_LAST);
    assign w_y_last = (r_y == V_LAST);

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (ena) begin
            if (w_x_last) begin
                w_x_nxt = 10'd0;
                w_y_nxt = w_y_last ? 10'd0 : r_y + 10'd1;
            end else begin
                w_x_nxt = r_x + 10'd1;
            end
        end
    end

    // Qualifiers are decoded from the next position so they land in the same cycle as the coordinate.
    assign w_hs_win   = (w_x_nxt >= HS_FIRST) && (w_x_nxt <= HS_LAST);
    assign w_vs_win   = (w_y_nxt >= VS_FIRST) && (w_y_nxt <= VS_LAST);
    assign w_disp_nxt = (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_hsync      <= ~SYNC_ACT;
            r_vsync      <= ~SYNC_ACT;
            r_display_on <= 1'b1;
        end else begin
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_hsync      <= w_hs_win ? SYNC_ACT : ~SYNC_ACT;
            r_vsync      <= w_vs_win ? SYNC_ACT : ~SYNC_ACT;
            r_display_on <= w_disp_nxt;
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign display_on = r_display_on;
    assign frame_tick = ena & w_x_last & w_y_last;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 8'd0;
        end else if (frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a full-size instance for line timing and a tiny, inverted-polarity
// instance for whole-frame, frame_tick and frame counter behaviour, both checked every cycle.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena_d = 1'b0;
    logic ena_s = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] x_d, y_d, x_s, y_s;
    logic       hs_d, vs_d, disp_d, ft_d, hs_s, vs_s, disp_s, ft_s;
    logic [7:0] fc_d, fc_s;

    vga_timing dut_d (
        .clk(clk), .rst_n(rst_n), .ena(ena_d),
        .x(x_d), .y(y_d), .hsync(hs_d), .vsync(vs_d),
        .display_on(disp_d), .frame_tick(ft_d), .frame_cnt(fc_d)
    );

    // 12 x 7 raster, active-high syncs: hsync on x 9..10, vsync on line 5.
    vga_timing #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .ena(ena_s),
        .x(x_s), .y(y_s), .hsync(hs_s), .vsync(vs_s),
        .display_on(disp_s), .frame_tick(ft_s), .frame_cnt(fc_s)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sync_lvl(input int p, input int first, input int len, input int pol);
        return (p >= first && p < first + len) ? pol : 1 - pol;
    endfunction

    // Reference position of each instance, advanced from the bench's own view of reset and enable.
    int         mxd = 0, myd = 0, mxs = 0, mys = 0;
    logic [7:0] mfd = 8'd0, mfs = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mxd <= 0; myd <= 0; mxs <= 0; mys <= 0;
            mfd <= 8'd0; mfs <= 8'd0;
        end else begin
            if (ena_d) begin
`ifdef VGA_TIMING_FRAME_CNT_EN
                if (mxd == 799 && myd == 524) mfd <= mfd + 8'd1;
`endif
                mxd <= (mxd + 1) % 800;
                if (mxd == 799) myd <= (myd + 1) % 525;
            end
            if (ena_s) begin
`ifdef VGA_TIMING_FRAME_CNT_EN
                if (mxs == 11 && mys == 6) mfs <= mfs + 8'd1;
`endif
                mxs <= (mxs + 1) % 12;
                if (mxs == 11) mys <= (mys + 1) % 7;
            end
        end
    end

    always @(negedge clk) begin
        chk("d_x", x_d, mxd);
        chk("d_y", y_d, myd);
        chk("d_hsync", hs_d, sync_lvl(mxd, 656, 96, 0));
        chk("d_vsync", vs_d, sync_lvl(myd, 490, 2, 0));
        chk("d_display_on", disp_d, (mxd < 640 && myd < 480) ? 1 : 0);
        chk("d_frame_tick", ft_d, (ena_d && mxd == 799 && myd == 524) ? 1 : 0);
        chk("d_frame_cnt", fc_d, mfd);
        chk("s_x", x_s, mxs);
        chk("s_y", y_s, mys);
        chk("s_hsync", hs_s, sync_lvl(mxs, 9, 2, 1));
        chk("s_vsync", vs_s, sync_lvl(mys, 5, 1, 1));
        chk("s_display_on", disp_s, (mxs < 8 && mys < 4) ? 1 : 0);
        chk("s_frame_tick", ft_s, (ena_s && mxs == 11 && mys == 6) ? 1 : 0);
        chk("s_frame_cnt", fc_s, mfs);
    end

    // Inputs change 2 time units after a rising edge, well clear of both clock edges.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int fc_exp;

    initial begin
        step(3);
        chk("rst_x", x_d, 0);
        chk("rst_y", y_d, 0);
        chk("rst_display_on", disp_d, 1);
        chk("rst_hsync", hs_d, 1);
        chk("rst_vsync", vs_d, 1);
        chk("rst_frame_cnt", fc_d, 0);
        chk("rst_s_hsync", hs_s, 0);
        rst_n = 1'b1;
        step(1);
        chk("idle_x", x_d, 0);

        ena_d = 1'b1;
        step(1);
        chk("first_x", x_d, 1);
        step(638);
        chk("x639_disp", disp_d, 1);
        step(1);
        chk("x640_disp", disp_d, 0);
        step(15);
        chk("x655_x", x_d, 655);
        chk("x655_hsync", hs_d, 1);

        ena_d = 1'b0;
        step(5);
        chk("frz_x", x_d, 655);
        chk("frz_hsync", hs_d, 1);
        chk("frz_tick", ft_d, 0);
        ena_d = 1'b1;
        step(1);
        chk("x656_x", x_d, 656);
        chk("x656_hsync", hs_d, 0);
        step(95);
        chk("x751_hsync", hs_d, 0);
        step(1);
        chk("x752_hsync", hs_d, 1);
        step(47);
        chk("x799_x", x_d, 799);
        chk("x799_y", y_d, 0);
        step(1);
        chk("wrap_x", x_d, 0);
        chk("wrap_y", y_d, 1);

        step(700);
        chk("pre_rst_x", x_d, 700);
        chk("pre_rst_hsync", hs_d, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_x", x_d, 0);
        chk("arst_y", y_d, 0);
        chk("arst_hsync", hs_d, 1);
        chk("arst_vsync", vs_d, 1);
        chk("arst_disp", disp_d, 1);
        ena_d = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);

        ena_s = 1'b1;
        step(1);
        chk("s_first_x", x_s, 1);
        step(82);
        chk("s_last_x", x_s, 11);
        chk("s_last_y", y_s, 6);
        chk("s_last_tick", ft_s, 1);
        ena_s = 1'b0;
        #1;
        chk("s_tick_gated", ft_s, 0);
        step(2);
        ena_s = 1'b1;
        step(1);
        chk("s_wrap_x", x_s, 0);
        chk("s_wrap_y", y_s, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc_exp = 1;
`else
        fc_exp = 0;
`endif
        chk("s_fc_1", fc_s, fc_exp);
        step(84 * 254);
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc_exp = 255;
`endif
        chk("s_fc_255", fc_s, fc_exp);
        step(84);
`ifdef VGA_TIMING_FRAME_CNT_EN
        fc_exp = 0;
`endif
        chk("s_fc_wrap", fc_s, fc_exp);

        step(63);
        chk("s_pre_rst_y", y_s, 5);
        chk("s_pre_rst_vsync", vs_s, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("s_arst_x", x_s, 0);
        chk("s_arst_vsync", vs_s, 0);
        chk("s_arst_hsync", hs_s, 0);
        chk("s_arst_fc", fc_s, 0);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
